// File: rtl/button_event_if.sv
// Button event bundle: debounced level in, registered event pulses out.
// Carries repeat_pulse only when BUTTON_AUTO_REPEAT_EN is defined.
interface button_event_if;
  logic filter_signal;
  logic press_pulse;
  logic release_pulse;
  logic click_pulse;
  logic double_pulse;
  logic long_pulse;
  logic held_level;
`ifdef BUTTON_AUTO_REPEAT_EN
  logic repeat_pulse;
`endif

  modport master (
    input  filter_signal,
    output press_pulse,
    output release_pulse,
    output click_pulse,
    output double_pulse,
    output long_pulse,
    output held_level
`ifdef BUTTON_AUTO_REPEAT_EN
    , output repeat_pulse
`endif
  );

  modport slave (
    output filter_signal,
    input  press_pulse,
    input  release_pulse,
    input  click_pulse,
    input  double_pulse,
    input  long_pulse,
    input  held_level
`ifdef BUTTON_AUTO_REPEAT_EN
    , input  repeat_pulse
`endif
  );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/click/double/long pulses.
// Optional auto-repeat while long-held: define BUTTON_AUTO_REPEAT_EN.
module button_event_decoder #(
  parameter logic [23:0] LONG_COUNT    = 24'd12_500_000,
  parameter logic [23:0] DOUBLE_GAP    = 24'd5_000_000,
  parameter logic [23:0] REPEAT_PERIOD = 24'd2_500_000,
  parameter int          CNT_W         = 24
) (
  input  logic          clock_source,
  input  logic          reset,
  button_event_if.master btn
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  // The counter holds (samples in state - 1): the entry sample is already
  // counted when the counter clears on the state change.
  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_COUNT - 24'd1);
  localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(DOUBLE_GAP - 24'd1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             level_q, held_q;
  logic             rise, fall;
  logic             press_q, release_q, click_q, double_q, long_q;
  logic             press_d, release_d, click_d, double_d, long_d;

  assign rise    = btn.filter_signal & ~level_q;
  assign fall    = ~btn.filter_signal & level_q;
  assign cnt_inc = sat_inc(cnt_q);

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_TERM = CNT_W'(REPEAT_PERIOD - 24'd1);

  logic [CNT_W-1:0] rep_q, rep_d;
  logic             repeat_q, repeat_d;

  // Wrapping phase counter, independent of the saturating hold counter.
  always_comb begin
    rep_d    = '0;
    repeat_d = 1'b0;
    if (state_q == LONG && !fall) begin
      if (rep_q == REP_TERM) begin
        repeat_d = 1'b1;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_source) begin
    if (reset) begin
      rep_q    <= '0;
      repeat_q <= 1'b0;
    end else begin
      rep_q    <= rep_d;
      repeat_q <= repeat_d;
    end
  end

  assign btn.repeat_pulse = repeat_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    double_d  = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          state_d = PRESS1;
        end
      end
      PRESS1: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = WAIT2;
        end else if (cnt_inc == LONG_TERM) begin
          long_d  = 1'b1;
          state_d = LONG;
        end
      end
      WAIT2: begin
        if (rise) begin
          press_d = 1'b1;
          state_d = PRESS2;
        end else if (cnt_inc == GAP_TERM) begin
          click_d = 1'b1;
          state_d = IDLE;
        end
      end
      PRESS2: begin
        if (fall) begin
          release_d = 1'b1;
          double_d  = 1'b1;
          state_d   = IDLE;
        end else if (cnt_inc == LONG_TERM) begin
          long_d  = 1'b1;
          state_d = LONG;
        end
      end
      LONG: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // level_q resets high so a button held through reset never looks like a press.
  always_ff @(posedge clock_source) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b1;
      held_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= btn.filter_signal;
      held_q    <= btn.filter_signal;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      double_q  <= double_d;
      long_q    <= long_d;
    end
  end

  assign btn.press_pulse   = press_q;
  assign btn.release_pulse = release_q;
  assign btn.click_pulse   = click_q;
  assign btn.double_pulse  = double_q;
  assign btn.long_pulse    = long_q;
  assign btn.held_level    = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder: expected pulses are queued per
// sample edge and compared by a falling-edge monitor.
module tb_button_event_decoder;

  localparam logic [5:0] EV_P = 6'b000001;
  localparam logic [5:0] EV_R = 6'b000010;
  localparam logic [5:0] EV_C = 6'b000100;
  localparam logic [5:0] EV_D = 6'b001000;
  localparam logic [5:0] EV_L = 6'b010000;
  localparam logic [5:0] EV_T = 6'b100000;

  typedef struct {
    int         edge_n;
    logic [5:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cur_edge = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  int   s;
  exp_t sb[$];

  button_event_if bus();

  button_event_decoder #(
    .LONG_COUNT   (24'd8),
    .DOUBLE_GAP   (24'd6),
    .REPEAT_PERIOD(24'd4),
    .CNT_W        (4)
  ) dut (
    .clock_source(clk),
    .reset       (rst),
    .btn         (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cur_edge++;

  function automatic logic [5:0] obs();
    logic rep;
`ifdef BUTTON_AUTO_REPEAT_EN
    rep = bus.repeat_pulse;
`else
    rep = 1'b0;
`endif
    return {rep, bus.long_pulse, bus.double_pulse, bus.click_pulse,
            bus.release_pulse, bus.press_pulse};
  endfunction

  always @(negedge clk) begin
    logic [5:0] m;
    exp_t       e;
    if (mon_en) begin
      m = obs();
      if (sb.size() > 0 && sb[0].edge_n == cur_edge) begin
        e = sb.pop_front();
        total++;
        assert (m === e.mask) else begin
          bad++;
          $error("FAIL event@%0d observed=%b expected=%b", cur_edge, m, e.mask);
        end
      end else if (m !== 6'b0) begin
        total++;
        assert (m === 6'b0) else begin
          bad++;
          $error("FAIL spurious@%0d observed=%b expected=%b", cur_edge, m, 6'b0);
        end
      end
    end
  end

  task automatic push(input int e, input logic [5:0] m);
    exp_t x;
    x.edge_n = e;
    x.mask   = m;
    sb.push_back(x);
  endtask

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      bus.filter_signal = v;
      @(negedge clk);
    end
  endtask

  task automatic check_drained(input string tag);
    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL %s pending=%0d expected=0", tag, sb.size());
    end
  endtask

  task automatic check_quiet(input string tag, input logic exp_held);
    logic [5:0] m;
    m = obs();
    total++;
    assert (m === 6'b0) else begin
      bad++;
      $error("FAIL %s pulses observed=%b expected=%b", tag, m, 6'b0);
    end
    total++;
    assert (bus.held_level === exp_held) else begin
      bad++;
      $error("FAIL %s held_level observed=%b expected=%b", tag, bus.held_level, exp_held);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.filter_signal = 1'b0;
    @(negedge clk);
    drive(1'b0, 2);
    check_quiet("reset_state", 1'b0);
    mon_en = 1'b1;
    rst = 1'b0;
    drive(1'b0, 3);

    // single click
    s = cur_edge + 1;
    push(s, EV_P); push(s + 3, EV_R); push(s + 8, EV_C);
    drive(1'b1, 3); drive(1'b0, 10);
    check_drained("single_click");

    // double click
    s = cur_edge + 1;
    push(s, EV_P); push(s + 3, EV_R); push(s + 7, EV_P); push(s + 10, EV_R | EV_D);
    drive(1'b1, 3); drive(1'b0, 4); drive(1'b1, 3); drive(1'b0, 10);
    check_drained("double_click");

    // gap reaches DOUBLE_GAP: two separate clicks
    s = cur_edge + 1;
    push(s, EV_P); push(s + 3, EV_R); push(s + 8, EV_C);
    push(s + 9, EV_P); push(s + 12, EV_R); push(s + 17, EV_C);
    drive(1'b1, 3); drive(1'b0, 6); drive(1'b1, 3); drive(1'b0, 10);
    check_drained("gap_boundary");

    // long press
    s = cur_edge + 1;
    push(s, EV_P); push(s + 7, EV_L);
`ifdef BUTTON_AUTO_REPEAT_EN
    push(s + 11, EV_T); push(s + 15, EV_T); push(s + 19, EV_T);
`endif
    push(s + 20, EV_R);
    drive(1'b1, 20); drive(1'b0, 10);
    check_drained("long_press");

    // held through reset
    rst = 1'b1;
    drive(1'b1, 3);
    check_quiet("held_in_reset", 1'b0);
    rst = 1'b0;
    drive(1'b1, 1);
    check_quiet("held_after_reset", 1'b1);
    drive(1'b1, 4); drive(1'b0, 10);
    check_drained("held_through_reset");

    // reset mid-gesture, then a normal click from IDLE
    s = cur_edge + 1;
    push(s, EV_P); push(s + 3, EV_R);
    drive(1'b1, 3); drive(1'b0, 2);
    rst = 1'b1;
    drive(1'b0, 1);
    rst = 1'b0;
    drive(1'b0, 10);
    check_drained("reset_mid_gesture");
    s = cur_edge + 1;
    push(s, EV_P); push(s + 3, EV_R); push(s + 8, EV_C);
    drive(1'b1, 3); drive(1'b0, 10);
    check_drained("click_after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumer end of the button path. Takes the debounced level from the debouncer and turns press gestures into single-cycle event pulses: press, release, click, double-click and long-press.
- Sits between the debounced button inputs and control logic such as menu FSMs and mode toggles.
- One instance per button.
- All timing is counted in clock_source cycles.

Parameters:
- LONG_COUNT, 24'd12_500_000, number of consecutive high samples that qualify as a long press (min 2).
- DOUBLE_GAP, 24'd5_000_000, maximum number of low samples between two presses that still counts as a double-click (min 2).
- REPEAT_PERIOD, 24'd2_500_000, spacing in samples between auto-repeat pulses while long-held (min 1); used only with the optional feature.
- CNT_W, 24, width of the shared cycle counter; must hold max(LONG_COUNT, DOUBLE_GAP, REPEAT_PERIOD).

Ports:
- clock_source, input, 1, sole clock; everything samples on its rising edge.
- reset, input, 1, synchronous, active-high reset.
- filter_signal, input, 1, debounced button level; 1 = pressed.
- press_pulse, output, 1, one-cycle pulse on every accepted rising edge.
- release_pulse, output, 1, one-cycle pulse on every accepted falling edge.
- click_pulse, output, 1, one-cycle pulse for a confirmed single short press.
- double_pulse, output, 1, one-cycle pulse for a confirmed double short press.
- long_pulse, output, 1, one-cycle pulse when a hold reaches LONG_COUNT.
- held_level, output, 1, registered copy of the sampled level.

Behaviour:
- Interface: one clock (clock_source); reset is synchronous and active-high.
- Input sampling: filter_signal is registered into level_q. rise = filter_signal & ~level_q; fall = ~filter_signal & level_q.
- Registered outputs: all outputs are registered. Each event pulse goes high for exactly one cycle, in the cycle after the edge where its condition is sampled. held_level = level_q.
- Reset: state=IDLE, counter=0, all pulse outputs 0, held_level 0. level_q resets to 1. A button held through reset therefore produces no press, and the resulting fall is ignored in IDLE.
- States: IDLE, PRESS1, WAIT2, PRESS2, LONG. The counter clears on every state change.
- IDLE:
  - rise → press_pulse, go to PRESS1.
  - Falls are ignored.
- PRESS1: counter counts high samples; the rise sample counts as 1.
  - Count reaches LONG_COUNT → long_pulse, go to LONG.
  - fall before that → release_pulse, go to WAIT2.
- WAIT2: counter counts low samples; the fall sample counts as 1.
  - Count reaches DOUBLE_GAP with no rise → click_pulse, go to IDLE.
  - rise before that → press_pulse, go to PRESS2.
  - If a rise lands on the sample after click_pulse, it is a fresh first press (IDLE path).
- PRESS2:
  - fall before LONG_COUNT → release_pulse and double_pulse in the same cycle, go to IDLE.
  - Count reaches LONG_COUNT → long_pulse, go to LONG. The double-click is cancelled; no click_pulse or double_pulse is generated.
- LONG:
  - fall → release_pulse, go to IDLE. No click.
  - Counter saturates at its maximum value; it never wraps.
- Event exclusivity: click_pulse, double_pulse and long_pulse are mutually exclusive per gesture.
  - Exactly one of them fires per gesture, except a gesture aborted by reset, which fires none.
  - press_pulse and release_pulse always alternate.
- Reset mid-gesture: the gesture is aborted with no pending click/double emitted, and the state returns to IDLE.
- Illegal state encoding: recovers to IDLE on the next cycle.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined:
  - Adds output repeat_pulse (1 bit, reset 0).
  - In LONG, repeat_pulse fires every REPEAT_PERIOD samples while the button stays held. The first pulse comes at hold count LONG_COUNT+REPEAT_PERIOD.
  - Repeat counting uses its own counter that wraps modulo REPEAT_PERIOD, so repeats continue for as long as the button is held.
  - Repeat stops on fall. No repeat_pulse fires on the release cycle.
- Undefined: the port, the repeat counter and the logic are absent; LONG holds silently until release.

Test Plan (bench parameters: LONG_COUNT=8, DOUBLE_GAP=6, REPEAT_PERIOD=4, CNT_W=4):
1. Single click: reset 2 cycles; filter_signal high 3 cycles, then low 10 → press_pulse once, release_pulse once, click_pulse 1 cycle after the 6th low sample; no double_pulse or long_pulse.
2. Double-click: high 3, low 4, high 3, low 10 → press_pulse ×2, release_pulse ×2, double_pulse in the same cycle as the second release_pulse; no click_pulse.
3. Double-gap boundary: high 3, low 6, high 3, low 10 → click_pulse, then a second click_pulse; never double_pulse.
4. Long press with BUTTON_AUTO_REPEAT_EN defined: high 20, low 10 → long_pulse 1 cycle after the 8th high sample; repeat_pulse after high samples 12, 16 and 20; release_pulse on release; no click_pulse.
5. Held through reset: filter_signal=1 while reset is asserted 3 cycles, held 5 more cycles, then low 10 → no outputs pulse at all.
6. Reset mid-gesture: high 3, low 2, reset 1 cycle, low 10 → press_pulse and release_pulse before reset, no click_pulse afterwards, state back in IDLE.
